// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
// Each requester has a valid/ready request channel and a valid/ready response
// channel. Grants alternate round-robin when both requesters are valid. An
// accepted operation runs IDLE -> EXEC -> RESP -> IDLE. The ALU inputs carry
// live values only during EXEC, and the result goes back to the requester
// that issued the operation.

module alu_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  // requester 0
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  // requester 1
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  // shared ALU
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [1:0]       ALUControl,
  input  logic [WIDTH-1:0] ALUResult,
  // status
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_last_grant;   // requester served most recently
  logic             r_owner;        // requester that owns the in-flight operation
  logic [WIDTH-1:0] r_a;            // operand a, visible to the ALU only in EXEC
  logic [WIDTH-1:0] r_b;            // operand b, visible to the ALU only in EXEC
  logic [1:0]       r_op;           // ALU control, visible to the ALU only in EXEC
  logic [WIDTH-1:0] r_result_q;     // ALU result captured at the end of EXEC
  logic             r_rsp0_valid;
  logic             r_rsp1_valid;
  logic             r_busy;

  logic             w_grant_valid;  // some requester is granted this cycle
  logic             w_grant;        // index of the granted requester
  logic             w_rsp_done;     // owner takes the response this cycle

  // Grant selection in IDLE. On a tie, the requester not served last wins.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant       = 1'b0;
    if (reset) begin
      w_grant_valid = 1'b0;
      w_grant       = 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (req0_valid && req1_valid) begin
        w_grant_valid = 1'b1;
        w_grant       = ~r_last_grant;
      end else if (req0_valid) begin
        w_grant_valid = 1'b1;
        w_grant       = 1'b0;
      end else if (req1_valid) begin
        w_grant_valid = 1'b1;
        w_grant       = 1'b1;
      end else begin
        w_grant_valid = 1'b0;
        w_grant       = 1'b0;
      end
    end else begin
      w_grant_valid = 1'b0;
      w_grant       = 1'b0;
    end
  end

  // Select the owner's response ready for the RESP handshake.
  always_comb begin
    w_rsp_done = 1'b0;
    if (r_owner) begin
      w_rsp_done = rsp1_ready;
    end else begin
      w_rsp_done = rsp0_ready;
    end
  end

  // Main FSM: accept, present operands for one cycle, then hold the response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_a          <= {WIDTH{1'b0}};
      r_b          <= {WIDTH{1'b0}};
      r_op         <= 2'b00;
      r_result_q   <= {WIDTH{1'b0}};
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_valid) begin
            r_a     <= w_grant ? req1_a  : req0_a;
            r_b     <= w_grant ? req1_b  : req0_b;
            r_op    <= w_grant ? req1_op : req0_op;
            r_owner <= w_grant;
            r_busy  <= 1'b1;
            r_state <= ST_EXEC;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          r_result_q   <= ALUResult;
          // Return the ALU inputs to zero as soon as the operation is done.
          r_a          <= {WIDTH{1'b0}};
          r_b          <= {WIDTH{1'b0}};
          r_op         <= 2'b00;
          r_rsp0_valid <= ~r_owner;
          r_rsp1_valid <= r_owner;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          if (w_rsp_done) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_last_grant <= r_owner;
            r_busy       <= 1'b0;
            r_state      <= ST_IDLE;
          end else begin
            r_state      <= ST_RESP;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_a          <= {WIDTH{1'b0}};
          r_b          <= {WIDTH{1'b0}};
          r_op         <= 2'b00;
          r_rsp0_valid <= 1'b0;
          r_rsp1_valid <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign req0_ready  = w_grant_valid & ~w_grant;
  assign req1_ready  = w_grant_valid &  w_grant;
  assign rsp0_valid  = r_rsp0_valid;
  assign rsp1_valid  = r_rsp1_valid;
  // Results read as zero whenever their valid is low.
  assign rsp0_result = r_rsp0_valid ? r_result_q : {WIDTH{1'b0}};
  assign rsp1_result = r_rsp1_valid ? r_result_q : {WIDTH{1'b0}};
  assign a           = r_a;
  assign b           = r_b;
  assign ALUControl  = r_op;
  assign busy        = r_busy;

  alu_arbiter_checker #(.WIDTH(WIDTH)) u_checker (
    .clk        (clk),
    .reset      (reset),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .rsp0_valid (rsp0_valid),
    .rsp1_valid (rsp1_valid),
    .rsp0_result(rsp0_result),
    .rsp1_result(rsp1_result),
    .a          (a),
    .b          (b),
    .ALUControl (ALUControl),
    .busy       (busy)
  );

endmodule

// Invariants of the arbiter's outputs, kept apart from the datapath.
module alu_arbiter_checker #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             reset,
  input logic             req0_ready,
  input logic             req1_ready,
  input logic             rsp0_valid,
  input logic             rsp1_valid,
  input logic [WIDTH-1:0] rsp0_result,
  input logic [WIDTH-1:0] rsp1_result,
  input logic [WIDTH-1:0] a,
  input logic [WIDTH-1:0] b,
  input logic [1:0]       ALUControl,
  input logic             busy
);

  a_one_rsp: assert property (@(posedge clk) disable iff (reset)
    !(rsp0_valid && rsp1_valid));

  a_one_grant: assert property (@(posedge clk) disable iff (reset)
    !(req0_ready && req1_ready));

  a_grant_idle: assert property (@(posedge clk) disable iff (reset)
    (req0_ready || req1_ready) |-> !busy);

  a_alu_quiet: assert property (@(posedge clk) disable iff (reset)
    !busy |-> (a == {WIDTH{1'b0}} && b == {WIDTH{1'b0}} && ALUControl == 2'b00));

  a_rsp0_zero: assert property (@(posedge clk) disable iff (reset)
    !rsp0_valid |-> (rsp0_result == {WIDTH{1'b0}}));

  a_rsp1_zero: assert property (@(posedge clk) disable iff (reset)
    !rsp1_valid |-> (rsp1_result == {WIDTH{1'b0}}));

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural ALU model.
module tb_alu_arbiter;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic             req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic             req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]       req0_op, req1_op;
  logic [WIDTH-1:0] rsp0_result, rsp1_result;
  logic [WIDTH-1:0] a, b, ALUResult;
  logic [1:0]       ALUControl;
  logic             busy;

  int checks;
  int failures;

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_result(rsp0_result),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_result(rsp1_result),
    .a          (a),
    .b          (b),
    .ALUControl (ALUControl),
    .ALUResult  (ALUResult),
    .busy       (busy)
  );

  // Behavioural model of the shared ALU
  always_comb begin
    case (ALUControl)
      2'b00:   ALUResult = a + b;
      2'b01:   ALUResult = a - b;
      2'b10:   ALUResult = a & b;
      2'b11:   ALUResult = a | b;
      default: ALUResult = 8'h00;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // One full operation through requester r with rsp ready held high.
  // Entered and left in IDLE at 2 time units after a rising edge.
  task automatic do_op(input int r, input logic [7:0] va, input logic [7:0] vb,
                       input logic [1:0] vop, input logic [7:0] exp);
    if (r == 0) begin
      req0_valid = 1'b1; req0_a = va; req0_b = vb; req0_op = vop;
    end else begin
      req1_valid = 1'b1; req1_a = va; req1_b = vb; req1_op = vop;
    end
    #1;
    check("accept_ready0", 32'(req0_ready), (r == 0) ? 32'd1 : 32'd0);
    check("accept_ready1", 32'(req1_ready), (r == 1) ? 32'd1 : 32'd0);
    step();
    // Scramble the request inputs: the operation in flight must not change.
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 8'hAA; req0_b = 8'h55; req0_op = 2'b11;
    req1_a = 8'hAA; req1_b = 8'h55; req1_op = 2'b11;
    #1;
    check("exec_busy", 32'(busy), 32'd1);
    check("exec_a", 32'(a), 32'(va));
    check("exec_b", 32'(b), 32'(vb));
    check("exec_op", 32'(ALUControl), 32'(vop));
    check("exec_rspv", 32'({rsp1_valid, rsp0_valid}), 32'd0);
    step();
    check("resp_v0", 32'(rsp0_valid), (r == 0) ? 32'd1 : 32'd0);
    check("resp_v1", 32'(rsp1_valid), (r == 1) ? 32'd1 : 32'd0);
    check("resp_result", 32'((r == 0) ? rsp0_result : rsp1_result), 32'(exp));
    check("resp_other0", 32'((r == 0) ? rsp1_result : rsp0_result), 32'd0);
    check("resp_alu_a", 32'(a), 32'd0);
    step();
    check("done_busy", 32'(busy), 32'd0);
    check("done_rspv", 32'({rsp1_valid, rsp0_valid}), 32'd0);
  endtask

  initial begin
    logic [7:0] held;
    checks = 0; failures = 0;
    reset = 1'b1;
    req0_valid = 1'b0; req0_a = 8'h00; req0_b = 8'h00; req0_op = 2'b00;
    req1_valid = 1'b0; req1_a = 8'h00; req1_b = 8'h00; req1_op = 2'b00;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    step(); step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rspv", 32'({rsp1_valid, rsp0_valid}), 32'd0);
    check("rst_alu", 32'({a, b, ALUControl}), 32'd0);
    reset = 1'b0;
    step();

    // Single add and the four ops through requester 1
    do_op(0, 8'd23, 8'd23, 2'b00, 8'd46);
    do_op(1, 8'd23, 8'd5, 2'b01, 8'd18);
    do_op(1, 8'hF0, 8'h3C, 2'b10, 8'h30);
    do_op(1, 8'hF0, 8'h3C, 2'b11, 8'hFC);
    do_op(1, 8'd200, 8'd100, 2'b00, 8'd44);

    // Contention from reset: both valid continuously
    reset = 1'b1;
    req0_valid = 1'b1; req0_a = 8'd1; req0_b = 8'd1; req0_op = 2'b00;
    req1_valid = 1'b1; req1_a = 8'd2; req1_b = 8'd2; req1_op = 2'b00;
    #1;
    check("cont_rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("cont_grant", 32'({req1_ready, req0_ready}), (i % 2 == 0) ? 32'd1 : 32'd2);
      step();
      check("cont_exec_ready", 32'({req1_ready, req0_ready}), 32'd0);
      step();
      check("cont_rspv", 32'({rsp1_valid, rsp0_valid}), (i % 2 == 0) ? 32'd1 : 32'd2);
      check("cont_result", 32'((i % 2 == 0) ? rsp0_result : rsp1_result), (i % 2 == 0) ? 32'd2 : 32'd4);
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();

    // Backpressure on requester 0 while requester 1 waits
    rsp0_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 8'd10; req0_b = 8'd20; req0_op = 2'b00;
    req1_valid = 1'b1; req1_a = 8'd7;  req1_b = 8'd3;  req1_op = 2'b01;
    #1;
    check("bp_grant", 32'({req1_ready, req0_ready}), 32'd1);
    step();
    req0_valid = 1'b0;
    step();
    held = rsp0_result;
    check("bp_result", 32'(held), 32'd30);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_v", 32'(rsp0_valid), 32'd1);
      check("bp_hold_r", 32'(rsp0_result), 32'(held));
      check("bp_r1_ready", 32'(req1_ready), 32'd0);
      step();
    end
    rsp0_ready = 1'b1;
    #1;
    check("bp_still_v", 32'(rsp0_valid), 32'd1);
    step();
    check("bp_r1_grant", 32'({req1_ready, req0_ready}), 32'd2);
    step();
    req1_valid = 1'b0;
    step();
    check("bp_r1_rsp", 32'(rsp1_valid), 32'd1);
    check("bp_r1_res", 32'(rsp1_result), 32'd4);
    step();

    // Reset during EXEC drops the operation
    req0_valid = 1'b1; req0_a = 8'd9; req0_b = 8'd9; req0_op = 2'b00;
    #1;
    check("mr_accept", 32'(req0_ready), 32'd1);
    step();
    check("mr_exec_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    req1_valid = 1'b1; req1_a = 8'd5; req1_b = 8'd5; req1_op = 2'b00;
    #1;
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_alu", 32'({a, b, ALUControl}), 32'd0);
    check("mr_ready", 32'({req1_ready, req0_ready}), 32'd0);
    check("mr_rspv", 32'({rsp1_valid, rsp0_valid}), 32'd0);
    step(); step();
    reset = 1'b0;
    #1;
    check("mr_grant0", 32'({req1_ready, req0_ready}), 32'd1);
    check("mr_no_rsp", 32'({rsp1_valid, rsp0_valid}), 32'd0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    check("mr_no_rsp2", 32'({rsp1_valid, rsp0_valid}), 32'd0);
    step();
    check("mr_new_rsp", 32'(rsp0_result), 32'd18);
    step();

    // Idle: ALU outputs quiet
    for (int i = 0; i < 10; i++) begin
      check("idle_a", 32'(a), 32'd0);
      check("idle_b", 32'(b), 32'd0);
      check("idle_op", 32'(ALUControl), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
